// File: rtl/matvec_pkg.sv
// Shared definitions for the matrix-vector engine front end and the engine itself.
package matvec_pkg;

    localparam int unsigned MV_N  = 128;
    localparam int unsigned MV_D  = 128;
    localparam int unsigned MV_DW = 32;

    typedef logic [MV_DW-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_X = 2'd1,
        LOAD_W = 2'd2,
        FULL   = 2'd3
    } ld_state_e;

endpackage

// File: rtl/matvec_operand_loader_if.sv
// Stream input and operand read ports between the loader, its source and the multiply engine.
interface matvec_operand_loader_if
    import matvec_pkg::*;
#(
    parameter int N  = MV_N,
    parameter int D  = MV_D,
    parameter int DW = MV_DW
);
    localparam int XAW = $clog2(N);
    localparam int WAW = $clog2(D * N);

    // Stream: a word moves on any rising edge where s_valid && s_ready; the source
    // holds s_data/s_last stable while s_valid is high and s_ready is low.
    logic           s_valid;
    logic           s_ready;
    logic [DW-1:0]  s_data;
    logic           s_last;

    logic           opnd_valid;
    logic           opnd_release;
    logic [XAW-1:0] x_rd_addr;
    logic [DW-1:0]  x_rd_data;
    logic [WAW-1:0] w_rd_addr;
    logic [DW-1:0]  w_rd_data;

    modport master (
        output s_valid, s_data, s_last, opnd_release, x_rd_addr, w_rd_addr,
        input  s_ready, opnd_valid, x_rd_data, w_rd_data
    );

    modport slave (
        input  s_valid, s_data, s_last, opnd_release, x_rd_addr, w_rd_addr,
        output s_ready, opnd_valid, x_rd_data, w_rd_data
    );

endinterface

// File: rtl/operand_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module operand_ram #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage is left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/matvec_operand_loader.sv
// Loads one framed stream (x then row-major W) into operand buffers and holds
// them for the multiply engine until it releases them.
module matvec_operand_loader
    import matvec_pkg::*;
#(
    parameter int N  = MV_N,
    parameter int D  = MV_D,
    parameter int DW = MV_DW
) (
    input  logic      clk,
    input  logic      rst,
    matvec_operand_loader_if.slave bus,
    output logic      frame_err,
    output logic      busy,
    output ld_state_e state_o
);

    localparam int XAW = $clog2(N);
    localparam int WAW = $clog2(D * N);
    localparam logic [XAW-1:0] X_LAST = XAW'(N - 1);
    localparam logic [WAW-1:0] W_LAST = WAW'(D * N - 1);

    ld_state_e      state_q, state_d;
    logic [XAW-1:0] xcnt_q, xcnt_d;
    logic [WAW-1:0] wcnt_q, wcnt_d;
    logic           opnd_valid_q, opnd_valid_d;
    logic           frame_err_q, frame_err_d;
    logic           x_we, w_we, fire;

    assign bus.s_ready    = (state_q == LOAD_X) || (state_q == LOAD_W);
    assign fire           = bus.s_valid && bus.s_ready;
    assign bus.opnd_valid = opnd_valid_q;
    assign frame_err      = frame_err_q;
    assign busy           = (state_q != IDLE);
    assign state_o        = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            xcnt_q       <= '0;
            wcnt_q       <= '0;
            opnd_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            xcnt_q       <= xcnt_d;
            wcnt_q       <= wcnt_d;
            opnd_valid_q <= opnd_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        xcnt_d       = xcnt_q;
        wcnt_d       = wcnt_q;
        opnd_valid_d = opnd_valid_q;
        frame_err_d  = 1'b0;
        x_we         = 1'b0;
        w_we         = 1'b0;
        case (state_q)
            IDLE: state_d = LOAD_X;
            LOAD_X: begin
                if (fire) begin
                    if (bus.s_last) begin
                        // Early s_last: drop the word and restart the frame.
                        frame_err_d = 1'b1;
                        xcnt_d      = '0;
                        wcnt_d      = '0;
                    end else begin
                        x_we = 1'b1;
                        if (xcnt_q == X_LAST) begin
                            xcnt_d  = '0;
                            state_d = LOAD_W;
                        end else begin
                            xcnt_d = xcnt_q + 1'b1;
                        end
                    end
                end
            end
            LOAD_W: begin
                if (fire) begin
                    if (wcnt_q == W_LAST) begin
                        // Missing s_last is flagged but the frame is still complete.
                        w_we         = 1'b1;
                        frame_err_d  = !bus.s_last;
                        opnd_valid_d = 1'b1;
                        state_d      = FULL;
                    end else if (bus.s_last) begin
                        frame_err_d = 1'b1;
                        xcnt_d      = '0;
                        wcnt_d      = '0;
                        state_d     = LOAD_X;
                    end else begin
                        w_we   = 1'b1;
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            FULL: begin
                if (bus.opnd_release) begin
                    opnd_valid_d = 1'b0;
                    wcnt_d       = '0;
                    state_d      = LOAD_X;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    operand_ram #(.DEPTH(N), .WIDTH(DW), .AW(XAW)) u_x_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (x_we),
        .waddr_i (xcnt_q),
        .wdata_i (bus.s_data),
        .raddr_i (bus.x_rd_addr),
        .rdata_o (bus.x_rd_data)
    );

    operand_ram #(.DEPTH(D * N), .WIDTH(DW), .AW(WAW)) u_w_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (w_we),
        .waddr_i (wcnt_q),
        .wdata_i (bus.s_data),
        .raddr_i (bus.w_rd_addr),
        .rdata_o (bus.w_rd_data)
    );

endmodule

// File: tb/tb_matvec_operand_loader.sv
// Directed bench for the operand loader with N=4, D=2 and a read-data scoreboard.
module tb_matvec_operand_loader;
  import matvec_pkg::*;

  localparam int N   = 4;
  localparam int D   = 2;
  localparam int DW  = 32;
  localparam int XAW = 2;
  localparam int WAW = 3;

  logic      clk = 1'b0;
  logic      rst;
  logic      frame_err;
  logic      busy;
  ld_state_e state_dbg;

  matvec_operand_loader_if #(.N(N), .D(D), .DW(DW)) bus ();

  matvec_operand_loader #(.N(N), .D(D), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .frame_err (frame_err),
    .busy      (busy),
    .state_o   (state_dbg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int err_pulses = 0;
  logic [DW-1:0] exp_q[$];
  bit tag_q[$];
  logic rd_pend = 1'b0;
  logic rd_vld = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: read data appears one cycle after the address is presented.
  always @(posedge clk) rd_vld <= rd_pend;

  always @(negedge clk) begin : monitor
    logic [DW-1:0] e;
    bit t;
    if (frame_err === 1'b1) err_pulses++;
    if (rd_vld) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_unexpected: read data with empty queue at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (t) check("w_rd_data", bus.w_rd_data, e);
        else   check("x_rd_data", bus.x_rd_data, e);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input bit is_w, input int addr, input logic [31:0] exp);
    if (is_w) bus.w_rd_addr = WAW'(addr);
    else      bus.x_rd_addr = XAW'(addr);
    exp_q.push_back(exp);
    tag_q.push_back(is_w);
    rd_pend = 1'b1;
    @(posedge clk);
    #1;
    rd_pend = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input bit last);
    int guard;
    guard = 0;
    bus.s_data  = d;
    bus.s_last  = last;
    bus.s_valid = 1'b1;
    while (bus.s_ready !== 1'b1 && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL s_ready_timeout: got s_ready=%b expected 1 for word %0d", bus.s_ready, d);
    end else begin
      @(posedge clk);
      #1;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_frame(input int xb, input int wb, input bit toggle, input bit last_ok);
    for (int i = 0; i < N; i++) begin
      send_word(32'(xb + i), 1'b0);
      if (toggle) idle(1);
    end
    for (int j = 0; j < D * N; j++) begin
      send_word(32'(wb + j), (j == D * N - 1) ? last_ok : 1'b0);
      if (toggle && j != D * N - 1) idle(1);
    end
  endtask

  task automatic release_ops();
    bus.opnd_release = 1'b1;
    @(posedge clk);
    #1;
    bus.opnd_release = 1'b0;
    check("release_opnd_valid", 32'(bus.opnd_valid), 0);
    check("release_s_ready", 32'(bus.s_ready), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid      = 1'b0;
    bus.s_data       = '0;
    bus.s_last       = 1'b0;
    bus.opnd_release = 1'b0;
    bus.x_rd_addr    = '0;
    bus.w_rd_addr    = '0;
    rst = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_s_ready", 32'(bus.s_ready), 0);
    check("rst_opnd_valid", 32'(bus.opnd_valid), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_x_rd_data", bus.x_rd_data, 0);
    check("rst_w_rd_data", bus.w_rd_data, 0);
    check("rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
    check("post_rst_state", 32'(state_dbg), 32'(LOAD_X));

    // Frame A: x=1..4, W=10..17
    for (int i = 0; i < N; i++) send_word(32'(1 + i), 1'b0);
    for (int j = 0; j < 7; j++) send_word(32'(10 + j), 1'b0);
    check("a_valid_before_last", 32'(bus.opnd_valid), 0);
    send_word(32'd17, 1'b1);
    check("a_valid_after_last", 32'(bus.opnd_valid), 1);
    check("a_state_full", 32'(state_dbg), 32'(FULL));
    check("a_no_err", 32'(frame_err), 0);
    rd(0, 2, 3);
    rd(1, 5, 15);
    rd(0, 0, 1);
    rd(1, 0, 10);

    // Stream pushing while FULL must be ignored
    bus.s_data  = 32'd99;
    bus.s_valid = 1'b1;
    idle(3);
    check("full_s_ready", 32'(bus.s_ready), 0);
    rd(0, 0, 1);
    rd(1, 7, 17);
    rd(1, 3, 13);
    bus.s_valid = 1'b0;
    check("full_still_valid", 32'(bus.opnd_valid), 1);
    release_ops();

    // Frame B with s_valid toggling
    send_frame(21, 30, 1'b1, 1'b1);
    check("b_valid", 32'(bus.opnd_valid), 1);
    rd(0, 0, 21);
    rd(0, 3, 24);
    rd(1, 5, 35);
    rd(1, 7, 37);
    release_ops();

    // Early s_last on the last x word
    for (int i = 0; i < 3; i++) send_word(32'(41 + i), 1'b0);
    send_word(32'd44, 1'b1);
    check("early_last_err", 32'(frame_err), 1);
    check("early_last_state", 32'(state_dbg), 32'(LOAD_X));
    idle(1);
    check("early_last_err_pulse", 32'(frame_err), 0);
    send_frame(51, 60, 1'b0, 1'b1);
    check("c_valid", 32'(bus.opnd_valid), 1);
    rd(0, 3, 54);
    rd(0, 1, 52);
    rd(1, 2, 62);
    rd(1, 0, 60);
    release_ops();

    // Final W word without s_last
    send_frame(71, 80, 1'b0, 1'b0);
    check("no_last_err", 32'(frame_err), 1);
    check("no_last_valid", 32'(bus.opnd_valid), 1);
    rd(1, 7, 87);
    rd(0, 2, 73);
    release_ops();

    // Reset in the middle of W loading
    for (int i = 0; i < N; i++) send_word(32'(91 + i), 1'b0);
    for (int j = 0; j < 5; j++) send_word(32'(100 + j), 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_opnd_valid", 32'(bus.opnd_valid), 0);
    check("midrst_s_ready", 32'(bus.s_ready), 0);
    check("midrst_state", 32'(state_dbg), 32'(IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_frame(111, 120, 1'b0, 1'b1);
    check("e_valid", 32'(bus.opnd_valid), 1);
    rd(0, 0, 111);
    rd(1, 4, 124);
    rd(1, 7, 127);
    release_ops();

    idle(2);
    check("frame_err_pulses", 32'(err_pulses), 2);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/matvec_operand_loader.md
Name: matvec_operand_loader

Overview:
Front end for the matrix-vector multiply engine. Accepts one serial stream of 32-bit words per frame: first the activation vector x (N words), then the weight matrix W in row-major order (D*N words). The words go into internal operand buffers. Once a frame is complete, the block exposes the buffers to the multiply engine through registered read ports. It holds them stable until the engine releases them, then accepts the next frame.

Parameters:
N, 128, columns of W and length of x
D, 128, rows of W (engine output length)
DW, 32, word width for x, W and the stream

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
s_valid  in  1  stream word valid
s_ready  out  1  loader can accept a word
s_data  in  DW  stream word
s_last  in  1  marks the final word of a frame (final W word)
opnd_valid  out  1  buffers hold a complete frame; contents stable
opnd_release  in  1  engine has finished with the buffers
x_rd_addr  in  clog2(N)  x read index
x_rd_data  out  DW  x[x_rd_addr], registered
w_rd_addr  in  clog2(D*N)  W read index, equal to row*N+col
w_rd_data  out  DW  W[w_rd_addr], registered
frame_err  out  1  one-cycle pulse on a framing error
busy  out  1  high when state is not IDLE

Behaviour:
- States: IDLE, LOAD_X, LOAD_W, FULL.
- Transfer rule: a word transfers when s_valid && s_ready in a cycle. s_ready = 1 only in LOAD_X and LOAD_W.
- Reset (asynchronous): state = IDLE, counters = 0, opnd_valid = 0, s_ready = 0, frame_err = 0, x_rd_data = 0, w_rd_data = 0. Buffer contents are not reset.
- IDLE: moves to LOAD_X on the first cycle after reset deassertion.
- LOAD_X:
  - each transfer writes x[xcnt] and increments xcnt.
  - the transfer with xcnt == N-1 clears xcnt and moves to LOAD_W.
- LOAD_W:
  - each transfer writes W[wcnt] and increments wcnt.
  - a transfer with wcnt == D*N-1 moves to FULL. opnd_valid rises on the next cycle, so the first cycle in FULL has opnd_valid = 1.
- FULL:
  - s_ready = 0; buffers are not written.
  - opnd_release (level, sampled while in FULL) clears opnd_valid and wcnt and moves to LOAD_X on the next cycle.
  - opnd_release outside FULL is ignored.
- Framing checks:
  - s_last on any transfer other than the final W word: frame_err pulses, the partial frame is discarded, counters clear, state goes to LOAD_X. The offending word is not stored.
  - Final W word arriving without s_last: frame_err pulses, but the frame is still accepted and the block enters FULL.
- Read ports: 1-cycle latency in every state; the data is meaningful only while opnd_valid = 1. Reads and writes to the same buffer do not conflict, because there are no writes in FULL.
- Reset mid-frame: the partial frame is lost. opnd_valid = 0 immediately (asynchronous), and loading restarts in LOAD_X.
- Throughput: one word per cycle with s_valid held high. A frame is N + D*N cycles, plus 1 cycle from FULL to LOAD_X after release.
- Storage: inferred RAM for W (D*N x DW) with one write port and one read port; x can be a register array.

Decomposition:
- Shared package matvec_pkg holds:
  - word typedef (DW bits);
  - state enum {IDLE, LOAD_X, LOAD_W, FULL};
  - default N, D, DW constants, reused by the matmul engine.
- One sub-module, operand_ram: simple dual-port synchronous RAM (write port plus registered read port, parameterised depth and width), instantiated for x and for W.

Test Plan:
- N=4, D=2: after reset, stream x = 1..4 then W = 10..17 with s_last on word 17 -> opnd_valid rises the cycle after word 17 transfers; x_rd_addr=2 returns 3; w_rd_addr=5 (row 1, col 1) returns 15, each one cycle after the address.
- Same frame with s_valid toggled every other cycle -> identical buffer contents; no transfer is counted while s_valid = 0.
- In FULL, drive s_valid = 1 with 99 -> s_ready = 0, buffers unchanged. Pulse opnd_release -> opnd_valid = 0 and s_ready = 1 next cycle; the next frame overwrites x[0].
- s_last on x word 3 -> frame_err pulses 1 cycle, state is LOAD_X, and a subsequent full correct frame loads correctly.
- Final W word sent without s_last -> frame_err pulses and opnd_valid still rises with correct data.
- Assert rst during LOAD_W after 5 W words -> opnd_valid = 0 and s_ready = 0 immediately; after release, a full frame loads and reads back correctly.
